fifo_push_arbiter: RTL and testbench

- Round-robin write-port arbiter and flush sequencer for the 64-deep single-clock FIFO.
- Shares the FIFO push/datain port between NREQ producers and gates the pop from one consumer.
- Keeps a registered shadow occupancy counter, so no grant decision depends on the FIFO's combinational full/empty/count outputs (these depend on push/pop and would form a loop).
- Provides a flush sequence that drains the FIFO to empty on command.

---
 rtl/fifo_arb_pkg.sv | 22 ++
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_push_arbiter.sv | 131 +++++++++++++
 tb/tb_fifo_push_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO push arbiter slice.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } arb_state_t;

  localparam int FIFO_WIDTH     = 8;
  localparam int FIFO_DEPTH     = 64;
  localparam int FIFO_LOG2DEPTH = 6;
  localparam int STAT_W         = 16;

  // Saturating increment for the per-producer grant counters.
  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request searching upward from ptr+1, modulo NREQ.
// Latency: purely combinational, zero cycles.
// Backpressure: enable low forces an all-zero grant; the caller holds ptr when nothing is granted.
module rr_pick #(
  parameter int NREQ = 4,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            enable,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx
);

  logic          found;
  logic [PW-1:0] cand;

  // Walk the NREQ slots after ptr in priority order and take the first requester.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr) + k) % NREQ);
      if (enable && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Round-robin push arbiter and flush sequencer in front of a single-clock FIFO (optional stats: FIFO_ARB_STATS_EN).
// Latency: grant, fifo_push and fifo_datain are combinational in the request cycle; occ/FSM update on the next edge.
// Backpressure: pushes stall when the shadow occupancy is full unless a pop happens in the same cycle; no grants in FLUSH/DONE.
module fifo_push_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = FIFO_WIDTH,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int LOG2DEPTH = FIFO_LOG2DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]        gnt,
  input  logic                   pop_req,
  output logic                   fifo_push,
  output logic [WIDTH-1:0]       fifo_datain,
  output logic                   fifo_pop,
  output logic [LOG2DEPTH:0]     occ,
  input  logic                   flush_req,
  output logic                   flush_busy,
  output logic                   flush_done,
  output logic [NREQ*STAT_W-1:0] gnt_cnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [LOG2DEPTH:0] OCC_FULL = (LOG2DEPTH+1)'(DEPTH);

  arb_state_t        state;
  logic [PW-1:0]     rr_ptr;
  logic [PW-1:0]     gnt_idx;
  logic              push_ok;
  logic [LOG2DEPTH:0] occ_next;

  // Pop and push permission come only from registered state and inputs, never from the FIFO's flags.
  assign fifo_pop  = ~rst & (occ != '0) & (pop_req | (state == FLUSH));
  assign push_ok   = ~rst & (state == ARB) & ((occ < OCC_FULL) | fifo_pop);
  assign fifo_push = |gnt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req    (req),
    .ptr    (rr_ptr),
    .enable (push_ok),
    .gnt    (gnt),
    .idx    (gnt_idx)
  );

  // One-hot AND-OR mux of the granted producer's data; zero when nothing is granted.
  always_comb begin
    fifo_datain = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) fifo_datain = fifo_datain | req_data[i*WIDTH +: WIDTH];
    end
  end

  // Shadow occupancy next value: simultaneous push and pop cancel out.
  always_comb begin
    occ_next = occ;
    if (fifo_push && !fifo_pop)      occ_next = occ + 1'b1;
    else if (fifo_pop && !fifo_push) occ_next = occ - 1'b1;
  end

  // Occupancy tracks the FIFO count register; the pointer moves only to a granted slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= '0;
      rr_ptr <= PW'(NREQ-1);
    end else begin
      occ <= occ_next;
      if (fifo_push) rr_ptr <= gnt_idx;
    end
  end

  // Flush sequencer: ARB -> FLUSH (drain) -> DONE (one-cycle pulse) -> ARB, with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB;
      flush_busy <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      flush_done <= 1'b0;
      unique case (state)
        ARB: begin
          if (flush_req) begin
            state      <= FLUSH;
            flush_busy <= 1'b1;
          end
        end
        FLUSH: begin
          if (occ_next == '0) begin
            state      <= DONE;
            flush_busy <= 1'b0;
            flush_done <= 1'b1;
          end
        end
        DONE: begin
          state <= ARB;
        end
        default: begin
          state      <= ARB;
          flush_busy <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];

  // Per-producer saturating grant counters, cleared by reset and by the end of a flush.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (rst || flush_done) cnt_q[i] <= '0;
      else if (gnt[i])       cnt_q[i] <= sat_inc(cnt_q[i]);
    end
  end

  // Pack the counters into the flat output bus, slot i at bits [i*STAT_W +: STAT_W].
  always_comb begin
    gnt_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
    end
  end
`else
  assign gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Directed bench for fifo_push_arbiter with a behavioural FIFO count model.
// Latency: inputs driven 1ns after posedge, outputs checked on the negedge.
// Backpressure: fills to full, pushes with a same-cycle pop, and drains through flush.
module tb_fifo_push_arbiter;
  import fifo_arb_pkg::*;

  localparam int NREQ      = 4;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 64;
  localparam int LOG2DEPTH = 6;

  logic                   clk = 1'b0;
  logic                   rst = 1'b1;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*WIDTH-1:0]  req_data = 32'h44332211;
  logic [NREQ-1:0]        gnt;
  logic                   pop_req = 1'b0;
  logic                   fifo_push;
  logic [WIDTH-1:0]       fifo_datain;
  logic                   fifo_pop;
  logic [LOG2DEPTH:0]     occ;
  logic                   flush_req = 1'b0;
  logic                   flush_busy;
  logic                   flush_done;
  logic [NREQ*STAT_W-1:0] gnt_cnt;

  int checks = 0;
  int errors = 0;
  int mcnt   = 0;

  always #5 clk = ~clk;

  fifo_push_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .LOG2DEPTH(LOG2DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .gnt         (gnt),
    .pop_req     (pop_req),
    .fifo_push   (fifo_push),
    .fifo_datain (fifo_datain),
    .fifo_pop    (fifo_pop),
    .occ         (occ),
    .flush_req   (flush_req),
    .flush_busy  (flush_busy),
    .flush_done  (flush_done),
    .gnt_cnt     (gnt_cnt)
  );

  // Stand-in for the FIFO's count register, driven only by the push/pop strobes.
  always @(posedge clk) begin
    if (rst) mcnt <= 0;
    else     mcnt <= mcnt + (fifo_push ? 1 : 0) - (fifo_pop ? 1 : 0);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    logic [3:0]  rr_gnt [5];
    logic [7:0]  rr_dat [5];
    logic [3:0]  sp_gnt [4];
    logic [7:0]  sp_dat [4];
    logic [63:0] exp_stats;

    rr_gnt = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rr_dat = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    sp_gnt = '{4'b0100, 4'b0001, 4'b0100, 4'b0001};
    sp_dat = '{8'h33, 8'h11, 8'h33, 8'h11};
`ifdef FIFO_ARB_STATS_EN
    exp_stats = {4{16'd2}};
`else
    exp_stats = '0;
`endif

    // Reset state with requests already asserted.
    req = 4'b1111;
    tick();
    settle();
    check("rst_gnt", gnt, 0);
    check("rst_push", fifo_push, 0);
    check("rst_datain", fifo_datain, 0);
    check("rst_pop", fifo_pop, 0);
    check("rst_occ", occ, 0);
    check("rst_busy", flush_busy, 0);
    check("rst_done", flush_done, 0);
    check("rst_gnt_cnt", gnt_cnt, 0);

    // Round-robin over all four producers.
    tick();
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      settle();
      check("rr_gnt", gnt, rr_gnt[k]);
      check("rr_data", fifo_datain, rr_dat[k]);
      check("rr_occ", occ, k);
      tick();
    end

    // Sparse requests: only slots 0 and 2.
    req = 4'b0101;
    for (int k = 0; k < 4; k++) begin
      settle();
      check("sp_gnt", gnt, sp_gnt[k]);
      check("sp_data", fifo_datain, sp_dat[k]);
      check("sp_occ", occ, 5 + k);
      tick();
    end

    // Flush request at occ=9 alongside a grant that still completes.
    req = 4'b1111;
    flush_req = 1'b1;
    settle();
    check("fl_req_gnt", gnt, 4'b0010);
    check("fl_req_data", fifo_datain, 8'h22);
    check("fl_req_busy", flush_busy, 0);
    tick();
    flush_req = 1'b0;
    for (int k = 0; k < 10; k++) begin
      settle();
      check("fl_busy", flush_busy, 1);
      check("fl_gnt", gnt, 0);
      check("fl_pop", fifo_pop, 1);
      check("fl_occ", occ, 10 - k);
      tick();
    end
    settle();
    check("fl_done", flush_done, 1);
    check("fl_done_busy", flush_busy, 0);
    check("fl_done_occ", occ, 0);
    check("fl_done_gnt", gnt, 0);
    check("fl_fifo_empty", mcnt == 0, 1);
    tick();
    settle();
    check("resume_gnt", gnt, 4'b0100);
    check("resume_done", flush_done, 0);
    check("resume_cnt_clr", gnt_cnt, 0);

    // Eight unstalled grants: two per producer.
    for (int k = 0; k < 8; k++) tick();
    settle();
    check("stats_cnt", gnt_cnt, exp_stats);
    check("stats_occ", occ, 8);

    // Fill to full.
    for (int k = 0; k < 56; k++) tick();
    settle();
    check("full_occ", occ, 64);
    check("full_gnt", gnt, 0);
    check("full_push", fifo_push, 0);
    check("full_model", mcnt, 64);

    // Push at full with a same-cycle pop.
    tick();
    pop_req = 1'b1;
    settle();
    check("fullpp_pop", fifo_pop, 1);
    check("fullpp_push", fifo_push, 1);
    check("fullpp_gnt", gnt, 4'b0100);
    check("fullpp_data", fifo_datain, 8'h33);
    tick();
    pop_req = 1'b0;
    req = 4'b0000;
    settle();
    check("fullpp_occ", occ, 64);
    check("fullpp_full", mcnt == 64, 1);

    // Reset during a flush at occ=5.
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b1111;
    for (int k = 0; k < 5; k++) tick();
    req = 4'b0000;
    flush_req = 1'b1;
    settle();
    check("mid_occ", occ, 5);
    tick();
    flush_req = 1'b0;
    rst = 1'b1;
    settle();
    check("mid_busy", flush_busy, 1);
    check("mid_pop_rst", fifo_pop, 0);
    tick();
    rst = 1'b0;
    settle();
    check("mid_occ0", occ, 0);
    check("mid_busy0", flush_busy, 0);
    check("mid_done0", flush_done, 0);
    tick();
    settle();
    check("mid_done_after", flush_done, 0);
    check("mid_busy_after", flush_busy, 0);

    // Flush with an empty FIFO.
    tick();
    flush_req = 1'b1;
    settle();
    check("e_busy0", flush_busy, 0);
    tick();
    flush_req = 1'b0;
    settle();
    check("e_busy1", flush_busy, 1);
    check("e_done1", flush_done, 0);
    check("e_pop1", fifo_pop, 0);
    tick();
    settle();
    check("e_done2", flush_done, 1);
    check("e_busy2", flush_busy, 0);
    tick();
    settle();
    check("e_done3", flush_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
